// File: rtl/pixel_word_writer.sv
// pixel_word_writer
//    Receives packed pixel words from the serial-to-parallel packer. Words
//    arrive as single-cycle strobes and cannot be stalled. They are buffered
//    in a small FIFO and written to frame memory over a req/ack port. Write
//    addresses are sequential within a frame.
//
// Ports
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    frame_start  one-cycle pulse: arm a new frame (also aborts a running one)
//    din/din_vld  packed word and its qualifying strobe
//    wr_req       memory write request, held until wr_ack
//    wr_addr      write word address (BASE_ADDR + words written, wraps)
//    wr_data      write data
//    wr_ack       memory accepts the pending request this cycle
//    frame_done   one-cycle pulse after the last word of the frame is acked
//    busy         a frame is armed and not yet complete
//    overflow     sticky: a word was dropped because the FIFO was full
//    level        FIFO occupancy, 0..DEPTH
module pixel_word_writer #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 16,
   parameter int FRAME_WORDS = 1200,
   parameter int BASE_ADDR   = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   frame_start,
   input  logic [DATA_W-1:0]      din,
   input  logic                   din_vld,
   output logic                   wr_req,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [DATA_W-1:0]      wr_data,
   input  logic                   wr_ack,
   output logic                   frame_done,
   output logic                   busy,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   // One extra bit so a frame of exactly 2^ADDR_W words can be counted.
   localparam int CNT_W = ADDR_W + 1;

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_WORDS);
   localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACK} state_t;

   state_t              state_q, state_d;

   logic                wr_req_q, wr_req_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                frame_done_q, frame_done_d;
   logic                busy_q, busy_d;
   logic                overflow_q, overflow_d;

   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
   logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;

   // head_q is the registered read port of the FIFO storage. head_ok_q says
   // that head_q holds the entry currently at rd_ptr_q.
   logic [DATA_W-1:0]   fifo_mem [DEPTH];
   logic [DATA_W-1:0]   head_q;
   logic                head_ok_q, head_ok_d;

   logic                active;
   logic                full;
   logic                want_push;
   logic                push;
   logic                pop;
   logic                drop;
   logic                last_word;

   // ---------------------------------------------------------------
   // FIFO control terms
   // ---------------------------------------------------------------
   always_comb begin
      active    = (state_q != S_IDLE);
      full      = (level_q == FULL_LVL);
      pop       = (state_q == S_ACK) && wr_req_q && wr_ack && !frame_start;
      // Words past the frame length are discarded without flagging overflow.
      want_push = active && din_vld && !frame_start && (acc_cnt_q < FRAME_CNT);
      push      = want_push && (!full || pop);
      drop      = want_push && full && !pop;
      last_word = ((wr_cnt_q + CNT_W'(1)) == FRAME_CNT);
   end

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (frame_start) begin
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (head_ok_q) state_d = S_ACK;
            S_ACK:   if (pop) state_d = last_word ? S_IDLE : S_RUN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // FSM outputs and datapath next values
   // ---------------------------------------------------------------
   always_comb begin
      wr_req_d     = wr_req_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      busy_d       = busy_q;
      overflow_d   = overflow_q | drop;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      acc_cnt_d    = acc_cnt_q;
      wr_cnt_d     = wr_cnt_q;
      level_d      = level_q;
      // head_q is only trusted when the entry existed before this edge and
      // rd_ptr_q is not moving on it.
      head_ok_d    = (level_q != '0) && !pop && !frame_start;

      if (push) begin
         wr_ptr_d  = wr_ptr_q + PTR_W'(1);
         acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      if (state_q == S_RUN && head_ok_q) begin
         wr_req_d  = 1'b1;
         wr_data_d = head_q;
      end

      if (pop) begin
         rd_ptr_d  = rd_ptr_q + PTR_W'(1);
         wr_cnt_d  = wr_cnt_q + CNT_W'(1);
         wr_addr_d = wr_addr_q + ADDR_W'(1);
         wr_req_d  = 1'b0;
         if (last_word) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            wr_addr_d    = BASE;
         end
      end

      // A new frame overrides everything, including a pending request.
      if (frame_start) begin
         wr_req_d     = 1'b0;
         wr_addr_d    = BASE;
         frame_done_d = 1'b0;
         busy_d       = 1'b1;
         overflow_d   = 1'b0;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         level_d      = '0;
         acc_cnt_d    = '0;
         wr_cnt_d     = '0;
      end
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_req_q     <= 1'b0;
         wr_addr_q    <= BASE;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         acc_cnt_q    <= '0;
         wr_cnt_q     <= '0;
         head_ok_q    <= 1'b0;
      end else begin
         wr_req_q     <= wr_req_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         overflow_q   <= overflow_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         acc_cnt_q    <= acc_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         head_ok_q    <= head_ok_d;
      end
   end

   // FIFO storage: no reset so it maps onto RAM with a registered read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= din;
      end
      head_q <= fifo_mem[rd_ptr_q];
   end

   assign wr_req     = wr_req_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;
   assign overflow   = overflow_q;
   assign level      = level_q;

endmodule
